// File: rtl/multicycle_control.sv
// Multicycle datapath controller with memory-wait timeout and sticky trap flags.
// Ports:
//   clk, rst_n            - system clock, asynchronous active-low reset
//   opcode[6:0]           - instruction opcode, stable from DECODE until FETCH
//   zero                  - ALU zero flag (branch decision)
//   mem_ready             - memory completes the current access this cycle
//   PCWrite .. ALUOp      - datapath strobes and mux selects
//   retire                - one-cycle pulse per completed instruction
//   illegal, bus_err      - sticky trap causes, cleared only by reset
//   state[3:0]            - current state code
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       PCSource,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       retire,
   output logic       illegal,
   output logic       bus_err,
   output logic [3:0] state
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      TRAP   = 4'd9
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_itype_q, is_itype_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic             wait_state;
   logic             timeout;

   // Memory-wait states share one counter; expiry only when the access is still pending.
   assign wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
   assign timeout    = wait_state && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   // State and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         cnt_q      <= '0;
         is_itype_q <= 1'b0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_itype_q <= is_itype_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Next state and strobes; strobes decode the state register directly so an
   // asynchronous reset removes them without waiting for a clock edge.
   always_comb begin
      state_d    = state_q;
      is_itype_d = is_itype_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      IorD       = 1'b0;
      ALUSrcA    = 1'b0;
      PCSource   = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      retire     = 1'b0;

      case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               state_d = DECODE;
            end else if (timeout) begin
               state_d   = TRAP;
               bus_err_d = 1'b1;
            end
         end
         DECODE: begin
            ALUSrcB    = 2'b10;
            is_itype_d = (opcode == OP_ITYPE);
            if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
               state_d = MEMADR;
            end else if ((opcode == OP_RTYPE) || (opcode == OP_ITYPE)) begin
               state_d = EXEC;
            end else if (opcode == OP_BRANCH) begin
               state_d = BRANCH;
            end else begin
               state_d   = TRAP;
               illegal_d = 1'b1;
            end
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_LOAD) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               state_d = MEMWB;
            end else if (timeout) begin
               state_d   = TRAP;
               bus_err_d = 1'b1;
            end
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            retire   = mem_ready;
            if (mem_ready) begin
               state_d = FETCH;
            end else if (timeout) begin
               state_d   = TRAP;
               bus_err_d = 1'b1;
            end
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = is_itype_q ? 2'b10 : 2'b00;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 2'b01;
            PCSource = 1'b1;
            PCWrite  = zero;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            // Unused codes 10-15 are treated as corruption.
            state_d   = TRAP;
            illegal_d = 1'b1;
         end
      endcase

      // Any transition clears the counter, which covers every entry into a wait state.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (wait_state && !mem_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign state   = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control. Each instruction is expanded into an
// expected per-cycle trace (state, inputs, trap flags) from its class latency and
// wait counts; strobes are checked against the per-state output table.
module tb_multicycle_control;

   localparam int unsigned TO = 4;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_TRAP   = 4'd9;

   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, IorD;
   logic       ALUSrcA, PCSource, retire, illegal, bus_err;
   logic [1:0] ALUSrcB, ALUOp;
   logic [3:0] state;
   logic [13:0] ctrl_w;

   multicycle_control #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IorD(IorD), .ALUSrcA(ALUSrcA),
      .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .retire(retire),
      .illegal(illegal), .bus_err(bus_err), .state(state)
   );

   always #5 clk = ~clk;

   assign ctrl_w = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, IorD,
                    ALUSrcA, PCSource, ALUSrcB, ALUOp, retire};

   typedef struct packed {
      logic [3:0] st;
      logic       rdy;
      logic       zr;
      logic       it;
      logic       ill;
      logic       be;
      logic [6:0] op;
   } ent_t;

   ent_t       tr_q[$];
   int         n_tests = 0;
   int         n_fail = 0;
   int         exp_retire = 0;
   int         got_retire = 0;
   logic [6:0] cur_op;
   logic       cur_it;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Strobe table per state, in the same bit order as ctrl_w.
   function automatic logic [13:0] exp_ctrl(input ent_t e);
      logic pcw, irw, rw, mr, mw, m2r, iord, sa, pcs, ret;
      logic [1:0] sb, aop;
      {pcw, irw, rw, mr, mw, m2r, iord, sa, pcs, ret} = '0;
      sb  = 2'b00;
      aop = 2'b00;
      case (e.st)
         S_FETCH:  begin mr = 1'b1; sb = 2'b01; irw = e.rdy; pcw = e.rdy; end
         S_DECODE: sb = 2'b10;
         S_MEMADR: begin sa = 1'b1; sb = 2'b10; end
         S_MEMRD:  begin mr = 1'b1; iord = 1'b1; end
         S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
         S_MEMWR:  begin mw = 1'b1; iord = 1'b1; ret = e.rdy; end
         S_EXEC:   begin sa = 1'b1; sb = e.it ? 2'b10 : 2'b00; aop = 2'b10; end
         S_ALUWB:  begin rw = 1'b1; ret = 1'b1; end
         S_BRANCH: begin sa = 1'b1; aop = 2'b01; pcs = 1'b1; pcw = e.zr; ret = 1'b1; end
         default:  ;
      endcase
      return {pcw, irw, rw, mr, mw, m2r, iord, sa, pcs, sb, aop, ret};
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic void push(input logic [3:0] st, input logic rdy, input logic zr,
                                input logic ill, input logic be);
      ent_t e;
      e.st = st; e.rdy = rdy; e.zr = zr; e.it = cur_it; e.ill = ill; e.be = be; e.op = cur_op;
      tr_q.push_back(e);
   endfunction

   // w low cycles then completion; w >= TO means TO low cycles and a bus trap.
   function automatic bit add_wait(input logic [3:0] st, input int w);
      for (int i = 0; i < ((w < TO) ? w : TO); i++) push(st, 1'b0, rb(), 1'b0, 1'b0);
      if (w >= TO) return 1'b1;
      push(st, 1'b1, rb(), 1'b0, 1'b0);
      return 1'b0;
   endfunction

   // cls: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 illegal. Returns 1 if it traps.
   function automatic bit gen(input int cls, input logic [6:0] op, input int wf, input int wm,
                              input logic zr, input int trap_len);
      bit bus, ill;
      bus = 1'b0; ill = 1'b0;
      cur_op = op;
      cur_it = (cls == 1);
      bus = add_wait(S_FETCH, wf);
      if (!bus) begin
         push(S_DECODE, rb(), rb(), 1'b0, 1'b0);
         case (cls)
            0, 1: begin
               push(S_EXEC, rb(), rb(), 1'b0, 1'b0);
               push(S_ALUWB, rb(), rb(), 1'b0, 1'b0);
            end
            2: begin
               push(S_MEMADR, rb(), rb(), 1'b0, 1'b0);
               bus = add_wait(S_MEMRD, wm);
               if (!bus) push(S_MEMWB, rb(), rb(), 1'b0, 1'b0);
            end
            3: begin
               push(S_MEMADR, rb(), rb(), 1'b0, 1'b0);
               bus = add_wait(S_MEMWR, wm);
            end
            4: push(S_BRANCH, rb(), zr, 1'b0, 1'b0);
            default: ill = 1'b1;
         endcase
      end
      if (bus || ill) begin
         for (int i = 0; i < trap_len; i++) push(S_TRAP, rb(), rb(), ill, bus);
      end
      return bus || ill;
   endfunction

   task automatic do_reset();
      ent_t e;
      e = '0;
      rst_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      check("rst_state", 32'(state), 32'(S_FETCH));
      check("rst_ctrl", 32'(ctrl_w), 32'(exp_ctrl(e)));
      check("rst_memwrite", 32'(MemWrite), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Drive each expected cycle at the falling edge and check before the rising edge.
   task automatic run_trace(input int abort_idx);
      for (int i = 0; i < tr_q.size(); i++) begin
         ent_t e;
         e = tr_q[i];
         @(negedge clk);
         opcode = e.op; mem_ready = e.rdy; zero = e.zr;
         #1;
         check("state", 32'(state), 32'(e.st));
         check("ctrl", 32'(ctrl_w), 32'(exp_ctrl(e)));
         check("illegal", 32'(illegal), 32'(e.ill));
         check("bus_err", 32'(bus_err), 32'(e.be));
         check("excl", 32'((MemRead & MemWrite) | (IRWrite & RegWrite)), 32'd0);
         if (retire) got_retire++;
         if (i == abort_idx) begin
            #1;
            do_reset();
            break;
         end
      end
   endtask

   task automatic run_one(input int cls, input logic [6:0] op, input int wf, input int wm,
                          input logic zr, input int trap_len);
      bit t;
      t = gen(cls, op, wf, wm, zr, trap_len);
      run_trace(-1);
      tr_q.delete();
      if (t) do_reset();
      else exp_retire++;
   endtask

   function automatic bit legal(input logic [6:0] op);
      return (op == OP_LD) || (op == OP_ST) || (op == OP_R) || (op == OP_I) || (op == OP_BR);
   endfunction

   function automatic int rand_wait();
      int r;
      r = int'($urandom_range(0, 15));
      return (r < 10) ? 0 : r - 9;
   endfunction

   initial begin
      opcode = 7'd0;
      zero = 1'b0;
      mem_ready = 1'b0;
      do_reset();

      run_one(0, OP_R, 0, 0, 1'b0, 0);
      run_one(1, OP_I, 0, 0, 1'b0, 0);
      run_one(2, OP_LD, 0, 3, 1'b0, 0);
      run_one(4, OP_BR, 0, 0, 1'b1, 0);
      run_one(4, OP_BR, 0, 0, 1'b0, 0);
      run_one(5, 7'b1111111, 0, 0, 1'b0, 20);
      run_one(0, OP_R, 4, 0, 1'b0, 3);
      run_one(0, OP_R, 3, 0, 1'b0, 0);
      run_one(3, OP_ST, 0, 4, 1'b0, 2);
      run_one(3, OP_ST, 1, 3, 1'b0, 0);

      // Asynchronous reset in the first MEMWR cycle of a store.
      void'(gen(3, OP_ST, 0, 2, 1'b0, 0));
      run_trace(3);
      tr_q.delete();

      for (int n = 0; n < 300; n++) begin
         int         r, cls;
         logic [6:0] op;
         r = int'($urandom_range(0, 19));
         cls = (r < 4) ? 0 : (r < 8) ? 1 : (r < 12) ? 2 : (r < 16) ? 3 : (r < 19) ? 4 : 5;
         case (cls)
            0: op = OP_R;
            1: op = OP_I;
            2: op = OP_LD;
            3: op = OP_ST;
            4: op = OP_BR;
            default: begin
               op = 7'($urandom);
               while (legal(op)) op = 7'($urandom);
            end
         endcase
         run_one(cls, op, rand_wait(), rand_wait(), rb(), int'($urandom_range(1, 4)));
      end

      check("retire_cnt", 32'(got_retire), 32'(exp_retire));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning max consecutive mem_ready-low cycles tolerated in a memory state (legal 2..256).
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port opcode  input  7  instruction opcode from the instruction register, stable from DECODE until FETCH.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have output ports PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, IorD, ALUSrcA, PCSource (1 bit each), ALUSrcB (2), ALUOp (2), and the datapath strobes they name.
REQ-008 SHALL have outputs retire (1, one-cycle pulse per completed instruction), illegal (1, sticky), bus_err (1, sticky) and state (4, current state code).

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, TRAP=9; codes 10-15 SHALL go to TRAP with illegal=1.
REQ-010 All outputs SHALL default to 0 in every state; only the values listed below SHALL be asserted.
REQ-011 FETCH: MemRead=1, ALUSrcB=01 (constant 4); IRWrite=PCWrite=mem_ready (Mealy); SHALL go to DECODE on mem_ready=1, otherwise hold.
REQ-012 DECODE: ALUSrcB=10 (imm); SHALL latch is_itype=(opcode==0010011); next state: 0000011 or 0100011 -> MEMADR, 0110011 or 0010011 -> EXEC, 1100011 -> BRANCH, any other opcode -> TRAP with illegal set.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; SHALL go to MEMRD if opcode==0000011, otherwise MEMWR.
REQ-014 MEMRD: MemRead=1, IorD=1; SHALL go to MEMWB on mem_ready=1, otherwise hold.
REQ-015 MEMWB: RegWrite=1, MemtoReg=1, retire=1; SHALL go to FETCH.
REQ-016 MEMWR: MemWrite=1, IorD=1; on mem_ready=1 SHALL assert retire=1 (Mealy) and go to FETCH, otherwise hold.
REQ-017 EXEC: ALUSrcA=1, ALUSrcB=10 if is_itype else 00, ALUOp=10; SHALL go to ALUWB.
REQ-018 ALUWB: RegWrite=1, MemtoReg=0, retire=1; SHALL go to FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=zero, retire=1; SHALL go to FETCH.
REQ-020 TRAP: all strobes 0, retire=0; SHALL remain in TRAP until reset.
REQ-021 Zero-wait latency (cycles, FETCH through last state): branch 3, R/I-ALU 4, store 4, load 5; each mem_ready-low cycle adds 1.
REQ-022 A wait counter (width clog2(MEM_TIMEOUT)) SHALL clear on entry to FETCH, MEMRD or MEMWR, and SHALL increment on each cycle in those states with mem_ready=0.
REQ-023 If mem_ready=0 and the counter equals MEM_TIMEOUT-1, the block SHALL go to TRAP and set bus_err the next cycle; mem_ready=1 on that same cycle SHALL take precedence (normal completion).
REQ-024 illegal and bus_err SHALL each be set only on entry to TRAP, SHALL never both be set by one event, and SHALL clear only by reset.
REQ-025 The block SHALL assert at most one of MemRead and MemWrite, and at most one of IRWrite and RegWrite, in any cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state=FETCH, clear the wait counter, is_itype, illegal and bus_err, regardless of the current state or any access in progress.
REQ-027 In FETCH after reset, the first rising edge with rst_n=1 and mem_ready=1 SHALL produce IRWrite=PCWrite=1 in that cycle.

Verification
REQ-028 R-type 0110011 with mem_ready held 1 -> states 0,1,6,7,0; RegWrite=1 only in ALUWB; retire pulses once; ALUSrcB=00 in EXEC.
REQ-029 Load 0000011 with mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; MemtoReg=1 and RegWrite=1 in MEMWB.
REQ-030 Branch 1100011, zero=1 then zero=0 on a repeat -> PCWrite=1 with PCSource=1 in the first BRANCH, PCWrite=0 in the second; retire pulses both times.
REQ-031 opcode 1111111 at DECODE -> TRAP (state=9), illegal=1, all strobes 0 for 20 cycles; rst_n pulse -> state=0, illegal=0.
REQ-032 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles, bus_err=1; repeat with mem_ready=1 on the 4th cycle -> DECODE, bus_err=0.
REQ-033 rst_n asserted asynchronously mid-MEMWR with MemWrite=1 -> MemWrite drops to 0 and state=0 before the next clock edge.
